// File: rtl/pipe_pkg.sv
// Shared types and constants for the Y86 pipeline hazard/forwarding control.
package pipe_pkg;

   localparam logic [3:0] REG_NONE = 4'hF;

   localparam logic [1:0] FWD_RF  = 2'd0;
   localparam logic [1:0] FWD_E2  = 2'd1;
   localparam logic [1:0] FWD_M_E = 2'd2;
   localparam logic [1:0] FWD_M_M = 2'd3;

   typedef struct packed {
      logic       valid;
      logic [3:0] dst_e;
      logic [3:0] dst_m;
      logic       is_load;
   } sb_entry_t;

   typedef enum logic [1:0] {
      ST_RUN,
      ST_RET_WAIT,
      ST_HALTED
   } ctrl_state_t;

   function automatic logic reg_hit(input logic [3:0] dst, input logic [3:0] src);
      return (dst != REG_NONE) && (dst == src);
   endfunction

   function automatic logic entry_hit(input sb_entry_t ent, input logic [3:0] src);
      return ent.valid && (reg_hit(ent.dst_e, src) || reg_hit(ent.dst_m, src));
   endfunction

   // Youngest producer wins; the select names where the value lives once the consumer reaches E.
   function automatic logic [1:0] fwd_select(input sb_entry_t e, input sb_entry_t e2,
                                             input logic [3:0] src);
      if (e.valid && reg_hit(e.dst_e, src))
         return FWD_E2;
      if (e2.valid && reg_hit(e2.dst_e, src))
         return FWD_M_E;
      if (e2.valid && reg_hit(e2.dst_m, src))
         return FWD_M_M;
      return FWD_RF;
   endfunction

endpackage

// File: rtl/pipe_scoreboard.sv
// In-flight destination tracker (E, E2, M, W) with hazard and forwarding-match logic.
// PIPE_FWD_EN selects forwarding with load-use detection; otherwise any RAW match stalls.
module pipe_scoreboard
   import pipe_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic       issue,
   input  logic       kill_e,
   input  sb_entry_t  d_entry,
   input  logic       d_valid,
   input  logic [3:0] d_srcA,
   input  logic [3:0] d_srcB,
   output logic       hazard,
   output logic [1:0] sel_a,
   output logic [1:0] sel_b
);

   sb_entry_t e_q, e2_q, m_q, w_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         e_q  <= '0;
         e2_q <= '0;
         m_q  <= '0;
         w_q  <= '0;
      end else begin
         e_q  <= issue  ? d_entry : '0;
         e2_q <= kill_e ? '0      : e_q;
         m_q  <= e2_q;
         w_q  <= m_q;
      end
   end

`ifdef PIPE_FWD_EN
   // A load's dstM only exists in M, so a consumer directly behind it must wait one cycle.
   assign hazard = d_valid && e_q.valid && e_q.is_load &&
                   (reg_hit(e_q.dst_m, d_srcA) || reg_hit(e_q.dst_m, d_srcB));
   assign sel_a  = fwd_select(e_q, e2_q, d_srcA);
   assign sel_b  = fwd_select(e_q, e2_q, d_srcB);
`else
   logic hit_a, hit_b;

   assign hit_a  = entry_hit(e_q, d_srcA) || entry_hit(e2_q, d_srcA) ||
                   entry_hit(m_q, d_srcA) || entry_hit(w_q, d_srcA);
   assign hit_b  = entry_hit(e_q, d_srcB) || entry_hit(e2_q, d_srcB) ||
                   entry_hit(m_q, d_srcB) || entry_hit(w_q, d_srcB);
   assign hazard = d_valid && (hit_a || hit_b);
   assign sel_a  = FWD_RF;
   assign sel_b  = FWD_RF;
`endif

   logic unused_sb;
   assign unused_sb = ^{e_q, e2_q, m_q, w_q};

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Y86 D->E->E2->M->W hazard controller: stall/bubble/squash, ret/halt sequencing, registered fwd selects.
// Build with PIPE_FWD_EN for operand forwarding; without it every RAW dependence stalls until W retires.
module pipe_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int RET_BUBBLES = 3
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       d_valid,
   input  logic [3:0] d_srcA,
   input  logic [3:0] d_srcB,
   input  logic [3:0] d_dstE,
   input  logic [3:0] d_dstM,
   input  logic       d_is_load,
   input  logic       d_is_ret,
   input  logic       d_is_halt,
   input  logic       e2_mispredict,
   output logic       f_stall,
   output logic       d_stall,
   output logic       d_bubble,
   output logic       e_bubble,
   output logic [1:0] fwdA_sel,
   output logic [1:0] fwdB_sel,
   output logic       halted
);

   localparam int CW = (RET_BUBBLES > 1) ? $clog2(RET_BUBBLES + 1) : 1;

   sb_entry_t   d_entry;
   logic        hazard, stall, issue;
   logic [1:0]  sel_a, sel_b;
   ctrl_state_t state;
   logic [CW-1:0] cnt;
   logic        hold_q, halted_q;

   assign d_entry = '{valid: 1'b1, dst_e: d_dstE, dst_m: d_dstM, is_load: d_is_load};

   // Mispredict squashes D and E, so it also cancels any stall request.
   assign stall = hazard && !e2_mispredict;
   assign issue = d_valid && !stall && !e2_mispredict;

   assign f_stall  = stall || hold_q;
   assign d_stall  = stall;
   assign d_bubble = e2_mispredict || hold_q;
   assign e_bubble = stall || e2_mispredict;
   assign halted   = halted_q;

   pipe_scoreboard u_scoreboard (
      .clock   (clock),
      .reset   (reset),
      .issue   (issue),
      .kill_e  (e2_mispredict),
      .d_entry (d_entry),
      .d_valid (d_valid),
      .d_srcA  (d_srcA),
      .d_srcB  (d_srcB),
      .hazard  (hazard),
      .sel_a   (sel_a),
      .sel_b   (sel_b)
   );

   // Selects follow the instruction into E; a non-issuing cycle leaves E empty, so read the regfile.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         fwdA_sel <= FWD_RF;
         fwdB_sel <= FWD_RF;
      end else begin
         fwdA_sel <= issue ? sel_a : FWD_RF;
         fwdB_sel <= issue ? sel_b : FWD_RF;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state    <= ST_RUN;
         cnt      <= '0;
         hold_q   <= 1'b0;
         halted_q <= 1'b0;
      end else begin
         case (state)
            ST_RUN: begin
               if (issue && d_is_ret) begin
                  state  <= ST_RET_WAIT;
                  cnt    <= CW'(RET_BUBBLES);
                  hold_q <= 1'b1;
               end else if (issue && d_is_halt) begin
                  state    <= ST_HALTED;
                  hold_q   <= 1'b1;
                  halted_q <= 1'b1;
               end
            end
            ST_RET_WAIT: begin
               cnt <= cnt - 1'b1;
               if (cnt == CW'(1)) begin
                  state  <= ST_RUN;
                  hold_q <= 1'b0;
               end
            end
            ST_HALTED: begin
               hold_q   <= 1'b1;
               halted_q <= 1'b1;
            end
            default: begin
               state    <= ST_RUN;
               cnt      <= '0;
               hold_q   <= 1'b0;
               halted_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; expectations follow whichever PIPE_FWD_EN build is compiled.
module tb_pipe_hazard_ctrl;
   import pipe_pkg::*;

   localparam logic [3:0] N = REG_NONE;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       d_valid, d_is_load, d_is_ret, d_is_halt, e2_mispredict;
   logic [3:0] d_srcA, d_srcB, d_dstE, d_dstM;
   logic       f_stall, d_stall, d_bubble, e_bubble, halted;
   logic [1:0] fwdA_sel, fwdB_sel;

   typedef struct {
      string      tag;
      logic [8:0] vec;
   } exp_t;

   exp_t exp_q[$];
   int   n_assert = 0;
   int   n_fail   = 0;

   always #5 clock = ~clock;

   pipe_hazard_ctrl #(.RET_BUBBLES(3)) dut (
      .clock         (clock),
      .reset         (reset),
      .d_valid       (d_valid),
      .d_srcA        (d_srcA),
      .d_srcB        (d_srcB),
      .d_dstE        (d_dstE),
      .d_dstM        (d_dstM),
      .d_is_load     (d_is_load),
      .d_is_ret      (d_is_ret),
      .d_is_halt     (d_is_halt),
      .e2_mispredict (e2_mispredict),
      .f_stall       (f_stall),
      .d_stall       (d_stall),
      .d_bubble      (d_bubble),
      .e_bubble      (e_bubble),
      .fwdA_sel      (fwdA_sel),
      .fwdB_sel      (fwdB_sel),
      .halted        (halted)
   );

   // {f_stall, d_stall, d_bubble, e_bubble, fwdA_sel, fwdB_sel, halted}
   function automatic logic [8:0] ev(input logic fs, input logic ds, input logic db, input logic eb,
                                     input logic [1:0] fa, input logic [1:0] fb, input logic h);
      return {fs, ds, db, eb, fa, fb, h};
   endfunction

   task automatic drive(input logic v, input logic [3:0] sa, input logic [3:0] sb,
                        input logic [3:0] de, input logic [3:0] dm, input logic ld = 1'b0,
                        input logic rt = 1'b0, input logic hl = 1'b0, input logic mp = 1'b0);
      d_valid = v; d_srcA = sa; d_srcB = sb; d_dstE = de; d_dstM = dm;
      d_is_load = ld; d_is_ret = rt; d_is_halt = hl; e2_mispredict = mp;
   endtask

   task automatic idle();
      drive(1'b0, N, N, N, N);
   endtask

   task automatic tick();
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic chk(input string tag, input logic [8:0] vec);
      exp_t       e;
      logic [8:0] obs;
      exp_q.push_back('{tag: tag, vec: vec});
      #1;
      e   = exp_q.pop_front();
      obs = {f_stall, d_stall, d_bubble, e_bubble, fwdA_sel, fwdB_sel, halted};
      n_assert++;
      assert (obs === e.vec)
      else begin
         n_fail++;
         $error("FAIL %s observed=%b expected=%b", e.tag, obs, e.vec);
      end
   endtask

   // Producer(s), optional idle gap, then a consumer; stall count and selects depend on the build.
   task automatic raw_case(input string tag, input int p_n,
                           input logic [3:0] p_sa, input logic [3:0] p_sb,
                           input logic [3:0] p_de, input logic [3:0] p_dm, input logic p_ld,
                           input int gap, input logic [3:0] c_sa, input logic [3:0] c_sb,
                           input int st_fwd, input int st_nofwd,
                           input logic [1:0] fa, input logic [1:0] fb);
      int st;
      for (int i = 0; i < p_n; i++) begin
         drive(1'b1, p_sa, p_sb, p_de, p_dm, p_ld);
         chk({tag, "_prod"}, '0);
         tick();
      end
      idle();
      for (int i = 0; i < gap; i++) tick();
`ifdef PIPE_FWD_EN
      st = st_fwd;
`else
      st = st_nofwd;
`endif
      drive(1'b1, c_sa, c_sb, 4'h7, N);
      for (int i = 0; i < st; i++) begin
         chk({tag, "_stall"}, ev(1, 1, 0, 1, 0, 0, 0));
         tick();
      end
      chk({tag, "_issue"}, '0);
      tick();
      idle();
`ifdef PIPE_FWD_EN
      chk({tag, "_sel"}, ev(0, 0, 0, 0, fa, fb, 0));
`else
      chk({tag, "_sel"}, '0);
`endif
      for (int i = 0; i < 4; i++) tick();
   endtask

   initial begin
      idle();
      repeat (2) @(negedge clock);
      chk("reset_state", '0);
      reset = 1'b0;
      tick();
      chk("idle_run", '0);
      tick();

      raw_case("alu_fwd_e",  1, 4'h0, 4'h3, 4'h3, N,    1'b0, 0, 4'h3, 4'h2, 0, 4, 2'd1, 2'd0);
      raw_case("load_use",   1, N,    4'h4, N,    4'h1, 1'b1, 0, N,    4'h1, 1, 4, 2'd0, 2'd3);
      raw_case("fwd_m_dste", 1, N,    N,    4'h2, N,    1'b0, 1, 4'h5, 4'h2, 0, 3, 2'd0, 2'd2);
      raw_case("pop_both",   1, 4'h4, 4'h4, 4'h4, 4'h6, 1'b1, 1, 4'h6, 4'h4, 0, 3, 2'd3, 2'd2);
      raw_case("youngest",   2, N,    N,    4'h0, N,    1'b0, 0, 4'h0, N,    0, 4, 2'd1, 2'd0);
      raw_case("reg_none",   1, N,    N,    N,    N,    1'b0, 0, N,    N,    0, 0, 2'd0, 2'd0);
      raw_case("w_stage",    1, N,    N,    4'h2, N,    1'b0, 3, 4'h2, N,    0, 1, 2'd0, 2'd0);

      // Mispredict on top of load-use: squash wins and the load never reaches E2 as valid.
      drive(1'b1, N, N, N, 4'h1, 1'b1);
      chk("mp_load", '0);
      tick();
      drive(1'b1, N, 4'h1, 4'h7, N, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("mp_override", ev(0, 0, 1, 1, 0, 0, 0));
      tick();
      drive(1'b1, N, 4'h1, 4'h7, N);
      chk("mp_no_stall", '0);
      tick();
      idle();
      chk("mp_load_killed", '0);
      for (int i = 0; i < 4; i++) tick();

      drive(1'b1, N, N, N, N, 1'b0, 1'b1, 1'b0, 1'b1);
      chk("mp_ret_squash", ev(0, 0, 1, 1, 0, 0, 0));
      tick();
      idle();
      chk("mp_ret_no_wait", '0);
      tick();

      // ret behind a load of %esp: stall first, then the three-cycle ret shadow.
      drive(1'b1, N, N, N, 4'h4, 1'b1);
      chk("ret_load", '0);
      tick();
      drive(1'b1, 4'h4, 4'h4, 4'h4, N, 1'b0, 1'b1);
`ifdef PIPE_FWD_EN
      chk("ret_lu_stall", ev(1, 1, 0, 1, 0, 0, 0));
      tick();
`else
      for (int i = 0; i < 4; i++) begin
         chk("ret_raw_stall", ev(1, 1, 0, 1, 0, 0, 0));
         tick();
      end
`endif
      chk("ret_issue", '0);
      tick();
      idle();
`ifdef PIPE_FWD_EN
      chk("ret_wait1", ev(1, 0, 1, 0, 3, 3, 0));
`else
      chk("ret_wait1", ev(1, 0, 1, 0, 0, 0, 0));
`endif
      tick();
      chk("ret_wait2", ev(1, 0, 1, 0, 0, 0, 0));
      tick();
      chk("ret_wait3", ev(1, 0, 1, 0, 0, 0, 0));
      tick();
      chk("ret_done", '0);
      for (int i = 0; i < 4; i++) tick();

      drive(1'b1, N, N, N, N, 1'b0, 1'b0, 1'b1);
      chk("halt_issue", '0);
      tick();
      idle();
      for (int i = 0; i < 10; i++) begin
         chk("halted_hold", ev(1, 0, 1, 0, 0, 0, 1));
         tick();
      end
      #2 reset = 1'b1;
      chk("halt_reset", '0);
      @(negedge clock);
      reset = 1'b0;
      chk("post_halt_reset", '0);
      tick();

      drive(1'b1, N, N, N, N, 1'b0, 1'b1);
      chk("ret2_issue", '0);
      tick();
      idle();
      chk("ret2_wait1", ev(1, 0, 1, 0, 0, 0, 0));
      #2 reset = 1'b1;
      chk("ret_async_reset", '0);
      @(negedge clock);
      reset = 1'b0;
      chk("after_reset_a", '0);
      tick();
      chk("after_reset_b", '0);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
